// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: instruction encoding
// constants, word-FIFO geometry and the FIFO entry record.
package instr_fetch_pkg;

    localparam logic [1:0] LONG_OPCODE = 2'b10;
    localparam int         HALF_W      = 16;
    localparam int         FIFO_DEPTH  = 2;
    localparam int         ENTRY_W     = 32;

    // One fetched ROM word together with where it came from and the
    // halfword slot at which execution enters it (1 = high half skipped).
    typedef struct packed {
        logic [ENTRY_W-1:0] word;
        logic [ENTRY_W-1:0] addr;
        logic               slot;
    } fetch_entry_t;

    // A word holds one long instruction when its top two bits carry the long opcode.
    function automatic logic is_long_opcode(input logic [1:0] top_bits);
        return top_bits == LONG_OPCODE;
    endfunction

endpackage

// File: rtl/instr_fetch_word_fifo.sv
// Two-entry synchronous FIFO holding fetched ROM words ahead of the decoder.
// Flush wins over push and pop in the same cycle.
import instr_fetch_pkg::*;

module fetch_word_fifo (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t push_entry_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [FIFO_DEPTH];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;

    // Pointer and occupancy update; flush empties the FIFO outright
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) wr_ptr_d = ~wr_ptr_q;
            if (pop_i)  rd_ptr_d = ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Per-core instruction fetch stage. Drives one ROM port, absorbs the ROM's
// one-cycle latency through a two-word FIFO, and splits each word into one
// long or two short instructions for the decoder. Branches flush.
// Optional feature: define FETCH_STATS_EN to add stat_issued/stat_bubbles.
import instr_fetch_pkg::*;

module instr_fetch #(
    parameter int               WIDTH     = 32,
    parameter int               ADDR_BITS = 15,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] rom_address,
    input  logic [WIDTH-1:0] rom_data,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr_word,
    output logic             instr_is_long,
    output logic [WIDTH-1:0] instr_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_bubbles
`endif
);

    localparam logic [ADDR_BITS-1:0] RESET_WORD = RESET_PC[ADDR_BITS:1];
    localparam logic                 RESET_SLOT = RESET_PC[0];

    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic                 entry_slot_q, entry_slot_d;
    logic                 inflight_q, inflight_d;
    logic                 hi_done_q, hi_done_d;
    logic [ADDR_BITS-1:0] inflight_addr_q;
    logic                 inflight_slot_q;

    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic [1:0]   fifo_count;
    logic         fifo_valid;
    logic         issue_slot;
    logic         head_long;
    logic         accept;
    logic         pop;
    logic         req;
    logic [2:0]   occupancy;

    assign fifo_valid = (fifo_count != 2'd0);
    // Entering a word at slot 1, or having issued its high half, means the low half is next.
    assign issue_slot = head.slot | hi_done_q;
    assign head_long  = is_long_opcode(head.word[31:30]) && !issue_slot;
    assign accept     = fifo_valid && instr_ready;
    assign pop        = accept && (head_long || issue_slot);
    // Counting the word leaving this cycle lets a long-only stream keep one word per cycle.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign req        = !branch_valid && (occupancy < 3'd2);

    assign push_entry = '{word: rom_data, addr: ENTRY_W'(inflight_addr_q), slot: inflight_slot_q};

    fetch_word_fifo u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (inflight_q),
        .pop_i        (pop),
        .flush_i      (branch_valid),
        .push_entry_i (push_entry),
        .head_o       (head),
        .count_o      (fifo_count)
    );

    // Next-state for fetch PC, entry slot, in-flight flag and half-issue tracking
    always_comb begin
        pc_d         = pc_q;
        entry_slot_d = entry_slot_q;
        inflight_d   = req;
        hi_done_d    = hi_done_q;
        if (branch_valid) begin
            pc_d         = branch_target[ADDR_BITS:1];
            entry_slot_d = branch_target[0];
            inflight_d   = 1'b0;
            hi_done_d    = 1'b0;
        end else begin
            if (req) begin
                pc_d         = pc_q + 1'b1;
                entry_slot_d = 1'b0;
            end
            if (pop)         hi_done_d = 1'b0;
            else if (accept) hi_done_d = 1'b1;
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_WORD;
            entry_slot_q <= RESET_SLOT;
            inflight_q   <= 1'b0;
            hi_done_q    <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            entry_slot_q <= entry_slot_d;
            inflight_q   <= inflight_d;
            hi_done_q    <= hi_done_d;
        end
    end

    // Remember which address/slot the outstanding ROM read belongs to
    always_ff @(posedge clk) begin
        if (req) begin
            inflight_addr_q <= pc_q;
            inflight_slot_q <= entry_slot_q;
        end
    end

    assign rom_address   = {{(WIDTH-ADDR_BITS){1'b0}}, pc_q};
    assign instr_valid   = fifo_valid;
    assign instr_is_long = fifo_valid && head_long;
    assign instr_word    = !fifo_valid ? 32'h0 :
                           head_long   ? head.word :
                           {{HALF_W{1'b0}}, issue_slot ? head.word[HALF_W-1:0] : head.word[31:HALF_W]};
    assign instr_pc      = !fifo_valid ? '0 :
                           {{(WIDTH-ADDR_BITS-1){1'b0}}, head.addr[ADDR_BITS-1:0], issue_slot};

    logic unused_bits;
    assign unused_bits = ^{branch_target[WIDTH-1:ADDR_BITS+1], head.addr[ENTRY_W-1:ADDR_BITS]};

`ifdef FETCH_STATS_EN
    logic [31:0] issued_q, bubbles_q;

    // Count accepted instructions and cycles where the decoder waited on fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q  <= 32'd0;
            bubbles_q <= 32'd0;
        end else begin
            if (accept)                     issued_q  <= issued_q + 32'd1;
            if (instr_ready && !fifo_valid) bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign stat_issued  = issued_q;
    assign stat_bubbles = bubbles_q;
`endif

endmodule
